// File: rtl/pkt_reader_pkg.sv
// Shared definitions for the FIFO packet reader: FSM states and header field layout.
package pkt_reader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_DROP    = 2'd2
    } state_e;

    localparam int LEN_LSB     = 0;
    localparam int LEN_MSB     = 15;
    localparam int TAG_LSB     = 16;
    localparam int TAG_MSB     = 31;
    localparam int TAG_W       = TAG_MSB - TAG_LSB + 1;
    localparam int DEF_MAX_LEN = 256;

endpackage

// File: rtl/fifo_pkt_reader_if.sv
// FIFO read port plus framed output stream of the packet reader.
interface fifo_pkt_reader_if
    import pkt_reader_pkg::*;
#(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] i_fifo_q;
    logic             i_fifo_empty;
    logic             o_fifo_rdreq;
    logic             o_valid;
    logic [WIDTH-1:0] o_data;
    logic             o_sop;
    logic             o_eop;
    logic [TAG_W-1:0] o_tag;
    logic             i_ready;

    modport master (
        input  i_fifo_q, i_fifo_empty, i_ready,
        output o_fifo_rdreq, o_valid, o_data, o_sop, o_eop, o_tag
    );

    modport slave (
        output i_fifo_q, i_fifo_empty, i_ready,
        input  o_fifo_rdreq, o_valid, o_data, o_sop, o_eop, o_tag
    );
endinterface

// File: rtl/fifo_pkt_reader.sv
// Pops header + payload words from a show-ahead FIFO and emits framed beats;
// packets with length 0 or above MAX_LEN are drained and counted instead.
module fifo_pkt_reader
    import pkt_reader_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int LEN_W   = 16,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int CNT_W   = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fifo_pkt_reader_if.master  bus,
    output logic [CNT_W-1:0]   o_pkt_cnt,
    output logic [CNT_W-1:0]   o_drop_cnt
);

    localparam logic [31:0] MAX_LEN_V = 32'(MAX_LEN);

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;
    logic [TAG_W-1:0] tag_hold_q, tag_hold_d;

    logic             vld_p1, vld_d;
    logic [WIDTH-1:0] data_p1, data_d;
    logic             sop_p1, sop_d;
    logic             eop_p1, eop_d;
    logic [TAG_W-1:0] tag_p1, tag_d;

    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic             rdreq;
    logic             pay_pop;
    logic             accept;
    logic [LEN_W-1:0] hdr_len;
    logic [TAG_W-1:0] hdr_tag;

    assign hdr_len = bus.i_fifo_q[LEN_LSB +: LEN_W];
    assign hdr_tag = bus.i_fifo_q[TAG_LSB +: TAG_W];
    assign accept  = vld_p1 & bus.i_ready;

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        first_d    = first_q;
        tag_hold_d = tag_hold_q;
        vld_d      = vld_p1;
        data_d     = data_p1;
        sop_d      = sop_p1;
        eop_d      = eop_p1;
        tag_d      = tag_p1;
        pkt_cnt_d  = pkt_cnt_q;
        drop_cnt_d = drop_cnt_q;
        rdreq      = 1'b0;
        pay_pop    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                rdreq = ~bus.i_fifo_empty;
                if (rdreq) begin
                    if (hdr_len == '0) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                    end else if (32'(hdr_len) > MAX_LEN_V) begin
                        rem_d   = hdr_len;
                        state_d = ST_DROP;
                    end else begin
                        rem_d      = hdr_len;
                        tag_hold_d = hdr_tag;
                        first_d    = 1'b1;
                        state_d    = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                // A stalled beat blocks further pops so the output register never overruns.
                rdreq = ~bus.i_fifo_empty & (~vld_p1 | bus.i_ready);
                if (rdreq) begin
                    pay_pop = 1'b1;
                    data_d  = bus.i_fifo_q;
                    vld_d   = 1'b1;
                    sop_d   = first_q;
                    eop_d   = (rem_q == LEN_W'(1));
                    tag_d   = tag_hold_q;
                    first_d = 1'b0;
                    rem_d   = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_DROP: begin
                rdreq = ~bus.i_fifo_empty;
                if (rdreq) begin
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        drop_cnt_d = drop_cnt_q + CNT_W'(1);
                        state_d    = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (!pay_pop && accept) begin
            vld_d = 1'b0;
        end
        if (accept && eop_p1) begin
            pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
        end
    end

    // p1: registered output beat and packet state
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rem_q      <= '0;
            first_q    <= 1'b0;
            tag_hold_q <= '0;
            vld_p1     <= 1'b0;
            data_p1    <= '0;
            sop_p1     <= 1'b0;
            eop_p1     <= 1'b0;
            tag_p1     <= '0;
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            tag_hold_q <= tag_hold_d;
            vld_p1     <= vld_d;
            data_p1    <= data_d;
            sop_p1     <= sop_d;
            eop_p1     <= eop_d;
            tag_p1     <= tag_d;
            pkt_cnt_q  <= pkt_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign bus.o_fifo_rdreq = rdreq & i_rst_n;
    assign bus.o_valid      = vld_p1;
    assign bus.o_data       = data_p1;
    assign bus.o_sop        = sop_p1;
    assign bus.o_eop        = eop_p1;
    assign bus.o_tag        = tag_p1;
    assign o_pkt_cnt        = pkt_cnt_q;
    assign o_drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_fifo_pkt_reader.sv
// Bench for fifo_pkt_reader: FIFO and packet-level reference model kept as queues.
module tb_fifo_pkt_reader;

    localparam int WIDTH   = 32;
    localparam int LEN_W   = 16;
    localparam int MAX_LEN = 256;
    localparam int CNT_W   = 16;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [15:0] tag;
    } beat_t;

    typedef struct {
        int          len;
        logic [15:0] tag;
        int          gap;
        int          rdy;
        int          pkt_d;
        int          drop_d;
    } vec_t;

    logic             i_clk = 1'b0;
    logic             i_rst_n;
    logic [CNT_W-1:0] pkt_cnt;
    logic [CNT_W-1:0] drop_cnt;

    fifo_pkt_reader_if #(.WIDTH(WIDTH)) ifc ();

    fifo_pkt_reader #(
        .WIDTH(WIDTH), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN), .CNT_W(CNT_W)
    ) dut (
        .i_clk(i_clk),
        .i_rst_n(i_rst_n),
        .bus(ifc),
        .o_pkt_cnt(pkt_cnt),
        .o_drop_cnt(drop_cnt)
    );

    always #5 i_clk = ~i_clk;

    logic [31:0] fifo_q[$];
    beat_t       exp_q[$];
    int          pop_log[$];
    int          beat_log[$];
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          gap_mode = 0;
    int          rdy_mode = 0;
    logic        rdy_force = 1'b1;
    int          exp_pkt = 0;
    int          exp_drop = 0;
    logic        held = 1'b0;
    beat_t       held_b;
    vec_t        vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_pkt(input int len, input logic [15:0] tag, input logic [31:0] base);
        logic [31:0] w;
        fifo_q.push_back({tag, 16'(len)});
        for (int i = 0; i < len; i++) begin
            w = (base == 32'd0) ? $urandom : base * 32'(i + 1);
            fifo_q.push_back(w);
            if (len >= 1 && len <= MAX_LEN)
                exp_q.push_back('{w, (i == 0), (i == len - 1), tag});
        end
        if (len == 0 || len > MAX_LEN) exp_drop++;
        else exp_pkt++;
    endtask

    // One clock cycle, entered and left at a falling edge.
    task automatic step();
        logic  pop;
        logic  gap;
        logic  rdy;
        beat_t e;
        case (gap_mode)
            1:       gap = cyc[0];
            2:       gap = ($urandom_range(0, 2) == 0);
            default: gap = 1'b0;
        endcase
        case (rdy_mode)
            1:       rdy = ($urandom_range(0, 3) != 0);
            2:       rdy = rdy_force;
            default: rdy = 1'b1;
        endcase
        ifc.i_fifo_empty = (fifo_q.size() == 0) || gap;
        ifc.i_fifo_q     = (fifo_q.size() != 0) ? fifo_q[0] : 32'd0;
        ifc.i_ready      = rdy;
        #1;
        pop = ifc.o_fifo_rdreq;
        if (ifc.i_fifo_empty) chk("rdreq_while_empty", 64'(pop), 64'd0);
        if (held)
            chk("stall_hold", {ifc.o_valid, ifc.o_data, ifc.o_sop, ifc.o_eop, ifc.o_tag},
                {1'b1, held_b.data, held_b.sop, held_b.eop, held_b.tag});
        if (ifc.o_valid && ifc.i_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual=%0h required=none", ifc.o_data);
            end else begin
                e = exp_q.pop_front();
                chk("beat", {ifc.o_data, ifc.o_sop, ifc.o_eop, ifc.o_tag},
                    {e.data, e.sop, e.eop, e.tag});
            end
            beat_log.push_back(cyc);
        end
        held   = ifc.o_valid & ~ifc.i_ready;
        held_b = '{ifc.o_data, ifc.o_sop, ifc.o_eop, ifc.o_tag};
        if (pop && fifo_q.size() != 0) begin
            void'(fifo_q.pop_front());
            pop_log.push_back(cyc);
        end
        @(negedge i_clk);
        cyc++;
    endtask

    task automatic drain(input int bound, input string name);
        int n = 0;
        while (!(fifo_q.size() == 0 && exp_q.size() == 0 && !ifc.o_valid) && n < bound) begin
            step();
            n++;
        end
        if (n >= bound) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout actual=%0d required<%0d", name, n, bound);
        end
    endtask

    task automatic clear_logs();
        pop_log.delete();
        beat_log.delete();
    endtask

    initial begin
        logic [CNT_W-1:0] p0, d0;
        int               np, n, len, r;

        vecs[0] = '{3,   16'h00AB, 0, 0, 1, 0};
        vecs[1] = '{0,   16'h0101, 0, 0, 0, 1};
        vecs[2] = '{300, 16'h0202, 0, 0, 0, 1};
        vecs[3] = '{1,   16'h0303, 0, 0, 1, 0};
        vecs[4] = '{4,   16'h0404, 1, 0, 1, 0};
        vecs[5] = '{256, 16'h0505, 0, 1, 1, 0};
        vecs[6] = '{257, 16'h0606, 2, 1, 0, 1};
        vecs[7] = '{2,   16'hFFFF, 2, 1, 1, 0};

        // Reset held with a non-empty FIFO: nothing may be popped or shown.
        i_rst_n          = 1'b0;
        ifc.i_ready      = 1'b1;
        push_pkt(3, 16'h00AB, 32'h11);
        ifc.i_fifo_empty = 1'b0;
        ifc.i_fifo_q     = fifo_q[0];
        repeat (3) @(negedge i_clk);
        #1;
        chk("reset_rdreq", 64'(ifc.o_fifo_rdreq), 64'd0);
        chk("reset_outputs", {ifc.o_valid, ifc.o_data, ifc.o_sop, ifc.o_eop, ifc.o_tag},
            64'd0);
        chk("reset_counters", {pkt_cnt, drop_cnt}, 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;

        clear_logs();
        step();
        chk("release_header_pop", 64'(pop_log.size()), 64'd1);
        drain(50, "single");
        chk("single_beats", 64'(beat_log.size()), 64'd3);
        if (beat_log.size() == 3 && pop_log.size() == 4)
            chk("single_hdr_to_eop", 64'(beat_log[2] - pop_log[0]), 64'd4);
        chk("single_pkt_cnt", 64'(pkt_cnt), 64'd1);

        // Backpressure on the 0x22 beat.
        clear_logs();
        rdy_mode  = 2;
        rdy_force = 1'b1;
        push_pkt(3, 16'h00AB, 32'h11);
        n = 0;
        while (!(ifc.o_valid && ifc.o_data == 32'h22) && n < 20) begin
            step();
            n++;
        end
        chk("bp_reach_22", 64'(ifc.o_valid && ifc.o_data == 32'h22), 64'd1);
        np        = pop_log.size();
        rdy_force = 1'b0;
        repeat (3) step();
        chk("bp_no_pop", 64'(pop_log.size()), 64'(np));
        chk("bp_still_22", {ifc.o_valid, ifc.o_data}, {1'b1, 32'h22});
        rdy_force = 1'b1;
        drain(50, "bp");
        chk("bp_beats", 64'(beat_log.size()), 64'd3);
        chk("bp_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkt)));
        rdy_mode = 0;

        // Illegal lengths are drained, then a single-beat packet goes through.
        clear_logs();
        d0 = drop_cnt;
        push_pkt(0, 16'h0001, 32'h0);
        push_pkt(300, 16'h0002, 32'h0);
        push_pkt(1, 16'h0077, 32'h55);
        drain(1000, "drop");
        chk("drop_delta", 64'(drop_cnt - d0), 64'd2);
        chk("drop_beats", 64'(beat_log.size()), 64'd1);

        // FIFO empty every other cycle.
        clear_logs();
        gap_mode = 1;
        push_pkt(4, 16'h0C0C, 32'h0);
        drain(100, "gap");
        chk("gap_beats", 64'(beat_log.size()), 64'd4);
        gap_mode = 0;

        // Back-to-back: header of the next packet right after the eop pop.
        clear_logs();
        push_pkt(2, 16'h0B0B, 32'h0);
        push_pkt(1, 16'h0B0C, 32'h0);
        drain(50, "b2b");
        chk("b2b_pops", 64'(pop_log.size()), 64'd5);
        if (pop_log.size() == 5)
            chk("b2b_hdr_gap", 64'(pop_log[3] - pop_log[2]), 64'd1);
        chk("b2b_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkt)));

        for (int v = 0; v < 8; v++) begin
            p0       = pkt_cnt;
            d0       = drop_cnt;
            gap_mode = vecs[v].gap;
            rdy_mode = vecs[v].rdy;
            push_pkt(vecs[v].len, vecs[v].tag, 32'h0);
            drain(4000, "vec");
            chk("vec_pkt_delta", 64'(pkt_cnt - p0), 64'(vecs[v].pkt_d));
            chk("vec_drop_delta", 64'(drop_cnt - d0), 64'(vecs[v].drop_d));
        end

        gap_mode = 2;
        rdy_mode = 1;
        for (int k = 0; k < 40; k++) begin
            r = $urandom_range(0, 9);
            if (r == 0) len = 0;
            else if (r == 1) len = $urandom_range(257, 270);
            else len = $urandom_range(1, 16);
            push_pkt(len, 16'($urandom), 32'h0);
        end
        drain(20000, "random");
        chk("random_pkt_cnt", 64'(pkt_cnt), 64'(16'(exp_pkt)));
        chk("random_drop_cnt", 64'(drop_cnt), 64'(16'(exp_drop)));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
